// File: rtl/rvga_icache.sv
// rvga_icache: direct-mapped read-only instruction cache refilled line-by-line from DDR
module rvga_icache #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_read,
    output logic [31:0] cpu_rdata,
    output logic        cpu_resp,
    input  logic        flush,
    output logic [31:0] ddr_addr,
    output logic        ddr_read,
    input  logic [31:0] ddr_rdata,
    output logic        ddr_write,
    output logic [31:0] ddr_wdata,
    input  logic        ddr_resp
);
    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TW = 30 - OB - IB;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t            state;
    logic [29:0]       la;
    logic [OB-1:0]     k;
    logic              flush_pend;
    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tag_mem [LINES];
    logic [31:0]       data_mem [LINES][WORDS];

    logic [TW-1:0] c_tag;
    logic [IB-1:0] c_idx;
    logic [OB-1:0] c_off;
    logic [TW-1:0] l_tag;
    logic [IB-1:0] l_idx;
    logic [OB-1:0] l_off;
    logic          hit;
    logic          last;
    logic          addr_unused;

    assign c_tag       = cpu_addr[31:OB+IB+2];
    assign c_idx       = cpu_addr[OB+IB+1:OB+2];
    assign c_off       = cpu_addr[OB+1:2];
    assign l_tag       = la[29:OB+IB];
    assign l_idx       = la[OB+IB-1:OB];
    assign l_off       = la[OB-1:0];
    assign addr_unused = ^cpu_addr[1:0];
    // a flush arriving with the lookup wins, so the request refills
    assign hit         = cpu_read && !flush && valid[c_idx] && tag_mem[c_idx] == c_tag;
    assign last        = k == OB'(WORDS - 1);
    assign ddr_write   = 1'b0;
    assign ddr_wdata   = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            la         <= '0;
            k          <= '0;
            flush_pend <= 1'b0;
            valid      <= '0;
            cpu_resp   <= 1'b0;
            cpu_rdata  <= '0;
            ddr_read   <= 1'b0;
            ddr_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush)
                        valid <= '0;
                    if (hit) begin
                        cpu_rdata <= data_mem[c_idx][c_off];
                        cpu_resp  <= 1'b1;
                        state     <= RESP;
                    end else if (cpu_read) begin
                        la       <= cpu_addr[31:2];
                        k        <= '0;
                        ddr_read <= 1'b1;
                        ddr_addr <= {cpu_addr[31:OB+2], {OB{1'b0}}, 2'b00};
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (flush)
                        flush_pend <= 1'b1;
                    if (ddr_resp) begin
                        if (k == l_off)
                            cpu_rdata <= ddr_rdata;
                        if (last) begin
                            ddr_read   <= 1'b0;
                            cpu_resp   <= 1'b1;
                            flush_pend <= 1'b0;
                            state      <= RESP;
                            // a flush seen during the refill also drops the new line
                            if (flush || flush_pend)
                                valid <= '0;
                            else
                                valid[l_idx] <= 1'b1;
                        end else begin
                            k        <= k + OB'(1);
                            ddr_addr <= ddr_addr + 32'd4;
                        end
                    end
                end
                default: begin
                    if (flush)
                        valid <= '0;
                    cpu_resp <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && ddr_resp) begin
            data_mem[l_idx][k] <= ddr_rdata;
            if (last)
                tag_mem[l_idx] <= l_tag;
        end
    end
endmodule

// File: tb/tb_rvga_icache.sv
// tb_rvga_icache: randomized fetch/flush/reset traffic against a transaction-level cache model
module tb_rvga_icache;
    localparam int LINES = 8;
    localparam int WORDS = 4;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_read = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_resp;
    logic        flush = 1'b0;
    logic [31:0] ddr_addr;
    logic        ddr_read;
    logic [31:0] ddr_rdata = '0;
    logic        ddr_write;
    logic [31:0] ddr_wdata;
    logic        ddr_resp = 1'b0;

    rvga_icache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_read(cpu_read),
        .cpu_rdata(cpu_rdata), .cpu_resp(cpu_resp), .flush(flush),
        .ddr_addr(ddr_addr), .ddr_read(ddr_read), .ddr_rdata(ddr_rdata),
        .ddr_write(ddr_write), .ddr_wdata(ddr_wdata), .ddr_resp(ddr_resp)
    );

    always #5 clk = ~clk;

    int          checks = 0, fails = 0, cyc = 0;
    int          issue_id = 0, done_id = 0, issue_cyc = 0, exp_edge = 0;
    bit          exp_valid = 0, exp_miss = 0, prev_resp = 0, lit_on = 0, scramble = 0;
    int          lit_miss = 0;
    logic [31:0] exp_addr = '0, lit_data = '0;
    logic [31:0] ddr_log [$];
    int          wait_cnt = 0, flush_word = -1;
    bit          mvalid [LINES];
    logic [31:0] mtag [LINES];

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / (4 * WORDS)) % LINES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (4 * WORDS * LINES);
    endfunction

    function automatic void clear_model();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endfunction

    // compare process: sees every edge (and the async reset assertion)
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] base;
        bit pending;
        if (clk) cyc++;
        #1;
        if (!rst_n) begin
            checks++;
            if (cpu_resp !== 1'b0 || ddr_read !== 1'b0 || ddr_addr !== 32'h0 || cpu_rdata !== 32'h0) begin
                fails++;
                $display("FAIL reset_state: resp=%b ddr_read=%b ddr_addr=%h rdata=%h, all must be 0", cpu_resp, ddr_read, ddr_addr, cpu_rdata);
            end
            prev_resp = 1'b0;
        end else begin
            base = exp_addr & ~32'(4 * WORDS - 1);
            pending = exp_valid && done_id != issue_id;
            checks++;
            if (ddr_write !== 1'b0 || ddr_wdata !== 32'h0) begin
                fails++;
                $display("FAIL write_path: ddr_write=%b ddr_wdata=%h, expected 0/0", ddr_write, ddr_wdata);
            end
            if (ddr_read) begin
                checks++;
                if (!(pending && exp_miss && ddr_log.size() < WORDS)) begin
                    fails++;
                    $display("FAIL ddr_read_stray: ddr_read=1 at addr %h with no refill outstanding", ddr_addr);
                end else if (ddr_addr !== base + 32'(4 * ddr_log.size())) begin
                    fails++;
                    $display("FAIL ddr_addr: got %h expected %h", ddr_addr, base + 32'(4 * ddr_log.size()));
                end
            end
            if (cpu_resp) begin
                checks++;
                if (prev_resp) begin
                    fails++;
                    $display("FAIL resp_width: cpu_resp high in two consecutive cycles");
                end
                if (!pending) begin
                    checks++;
                    fails++;
                    $display("FAIL resp_stray: cpu_resp=1 rdata=%h with no request outstanding", cpu_rdata);
                end else begin
                    checks++;
                    if (cpu_rdata !== ((exp_addr & ~32'h3) ^ K)) begin
                        fails++;
                        $display("FAIL rdata: addr %h got %h expected %h", exp_addr, cpu_rdata, (exp_addr & ~32'h3) ^ K);
                    end
                    checks++;
                    if (cyc != exp_edge) begin
                        fails++;
                        $display("FAIL latency: addr %h resp at edge %0d expected edge %0d", exp_addr, cyc, exp_edge);
                    end
                    checks++;
                    if (ddr_log.size() != (exp_miss ? WORDS : 0)) begin
                        fails++;
                        $display("FAIL refill_words: addr %h got %0d ddr words expected %0d", exp_addr, ddr_log.size(), exp_miss ? WORDS : 0);
                    end
                    if (lit_on) begin
                        checks += 2;
                        if (int'(exp_miss) != lit_miss) begin
                            fails++;
                            $display("FAIL model_miss: addr %h model miss=%0d expected %0d", exp_addr, exp_miss, lit_miss);
                        end
                        if (cpu_rdata !== lit_data) begin
                            fails++;
                            $display("FAIL literal_rdata: addr %h got %h expected %h", exp_addr, cpu_rdata, lit_data);
                        end
                    end
                    done_id = issue_id;
                end
            end else if (pending && cyc > issue_cyc + 100) begin
                checks++;
                fails++;
                $display("FAIL timeout: addr %h no cpu_resp within 100 cycles", exp_addr);
                done_id = issue_id;
            end
            prev_resp = cpu_resp;
        end
    end

    // one negedge step: DDR responder with 3-cycle latency plus pulse housekeeping
    task automatic tick();
        @(negedge clk);
        flush = 1'b0;
        if (ddr_resp) begin
            ddr_resp = 1'b0;
            wait_cnt = 0;
        end else if (ddr_read) begin
            wait_cnt++;
            if (wait_cnt == 3) begin
                ddr_resp = 1'b1;
                ddr_rdata = ddr_addr ^ K;
                ddr_log.push_back(ddr_addr);
                if (ddr_log.size() == flush_word + 1) begin
                    flush = 1'b1;
                    clear_model();
                end
                if (ddr_log.size() == WORDS) exp_edge = cyc + 1;
            end
        end else begin
            wait_cnt = 0;
        end
        if (scramble && exp_valid && exp_miss && done_id != issue_id)
            cpu_addr = $urandom();
    endtask

    task automatic issue(input logic [31:0] a, input bit wf, input int fw, input int lm, input logic [31:0] ld);
        int ix;
        bit hit;
        tick();
        if (wf) begin
            flush = 1'b1;
            clear_model();
        end
        ix = idx_of(a);
        hit = mvalid[ix] && mtag[ix] == tag_of(a);
        if (!hit) begin
            mvalid[ix] = 1'b1;
            mtag[ix] = tag_of(a);
        end
        exp_addr = a;
        exp_miss = !hit;
        exp_edge = hit ? cyc + 1 : -1;
        ddr_log.delete();
        flush_word = fw;
        lit_on = lm >= 0;
        lit_miss = lm;
        lit_data = ld;
        issue_cyc = cyc;
        cpu_addr = a;
        cpu_read = 1'b1;
        exp_valid = 1'b1;
        issue_id++;
    endtask

    task automatic fetch(input logic [31:0] a, input bit wf, input int fw, input bit rf, input int lm, input logic [31:0] ld);
        issue(a, wf, fw, lm, ld);
        for (int i = 0; i < 200 && done_id != issue_id; i++) tick();
        if (done_id != issue_id) begin
            $display("FAIL fetch_hang: no completion for %h", a);
            $fatal(1, "fetch did not complete");
        end
        if (rf) begin
            flush = 1'b1;
            clear_model();
        end
        tick();
        cpu_read = 1'b0;
        flush_word = -1;
    endtask

    task automatic idle_flush();
        tick();
        cpu_read = 1'b0;
        flush = 1'b1;
        clear_model();
        tick();
    endtask

    task automatic fetch_reset(input logic [31:0] a);
        issue(a, 1'b0, -1, -1, '0);
        for (int i = 0; i < 100 && ddr_log.size() < 2; i++) tick();
        if (ddr_log.size() < 2) begin
            $display("FAIL reset_fill_hang: refill of %h stalled", a);
            $fatal(1, "refill stalled");
        end
        tick();
        rst_n = 1'b0;
        exp_valid = 1'b0;
        cpu_read = 1'b0;
        clear_model();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        ddr_resp = 1'b1;
        ddr_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
    endtask

    initial begin
        clear_model();
        repeat (3) tick();
        rst_n = 1'b1;
        fetch(32'h14, 0, -1, 0, 1, 32'hA5A5_0014);
        fetch(32'h18, 0, -1, 0, 0, 32'hA5A5_0018);
        fetch(32'h94, 0, -1, 0, 1, 32'hA5A5_0094);
        fetch(32'h14, 0, -1, 0, 1, 32'hA5A5_0014);
        fetch(32'h20, 0,  1, 0, 1, 32'hA5A5_0020);
        fetch(32'h20, 0, -1, 0, 1, 32'hA5A5_0020);
        fetch_reset(32'h40);
        fetch(32'h40, 0, -1, 0, 1, 32'hA5A5_0040);
        fetch(32'h44, 1, -1, 0, 1, 32'hA5A5_0044);
        fetch(32'h48, 0, -1, 1, 0, 32'hA5A5_0048);
        fetch(32'h48, 0, -1, 0, 1, 32'hA5A5_0048);
        fetch(32'h4C, 0, -1, 0, 0, 32'hA5A5_004C);
        idle_flush();
        fetch(32'h4C, 0, -1, 0, 1, 32'hA5A5_004C);
        fetch(32'h10, 0, -1, 0, 1, 32'hA5A5_0010);
        fetch(32'h14, 0, -1, 0, 0, 32'hA5A5_0014);
        fetch(32'h18, 0, -1, 0, 0, 32'hA5A5_0018);
        scramble = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a ^ 32'hF000_0000;
            if ($urandom_range(0, 19) == 0) idle_flush();
            fetch(a, $urandom_range(0, 9) == 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                  $urandom_range(0, 9) == 0, -1, '0);
        end
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/rvga_icache.md
RVGA_ICACHE -- requirements
Module: rvga_icache

Interface
REQ-001 SHALL have parameter: LINES, 8, number of direct-mapped lines (power of 2, >=2).
REQ-002 SHALL have parameter: WORDS, 4, 32-bit words per line (power of 2, >=2).
REQ-003 SHALL have ports (clock and reset first):
 clk  in  1  single clock; all state updates on posedge.
 rst_n  in  1  reset, asynchronous, active-low.
 cpu_addr  in  32  fetch byte address; bits [1:0] ignored.
 cpu_read  in  1  fetch request; held high until cpu_resp.
 cpu_rdata  out  32  fetched word; valid only while cpu_resp=1.
 cpu_resp  out  1  one-cycle completion pulse.
 flush  in  1  one-cycle pulse; invalidate all lines.
 ddr_addr  out  32  refill word address, word-aligned.
 ddr_read  out  1  refill read request; held until ddr_resp.
 ddr_rdata  in  32  refill data; valid while ddr_resp=1.
 ddr_write  out  1  constant 0.
 ddr_wdata  out  32  constant 0.
 ddr_resp  in  1  one-cycle DDR completion pulse.
REQ-004 Address split SHALL be: word offset [log2(WORDS)+1:2], index next log2(LINES) bits, tag the remaining upper bits.

Function
REQ-005 State machine SHALL have states IDLE, FILL, RESP.
REQ-006 IDLE, cpu_read=1, line valid and tag match (hit): SHALL latch word, go RESP.
REQ-007 IDLE, cpu_read=1, miss: SHALL latch cpu_addr, clear refill counter k=0, go FILL.
REQ-008 FILL: ddr_read SHALL be 1, ddr_addr = {latched tag, latched index, k, 2'b00}; k counts 0..WORDS-1 in ascending order (line base first, not critical-word-first).
REQ-009 FILL, ddr_resp=1: SHALL write ddr_rdata into data[index][k]; if k=WORDS-1 write tag, set valid, capture requested word, go RESP; else k+1, stay FILL.
REQ-010 ddr_read SHALL deassert in the cycle after the ddr_resp for the last word (registered output); between words ddr_read MAY stay high with ddr_addr advancing in the cycle after each ddr_resp.
REQ-011 RESP: cpu_resp=1 for exactly one cycle, cpu_rdata = captured word; next state IDLE unconditionally.
REQ-012 cpu_read SHALL be ignored in RESP; requester drops or changes cpu_read/cpu_addr the cycle after cpu_resp.
REQ-013 Hit latency: request seen in IDLE at edge N -> cpu_resp high in cycle N+1 (1 cycle).
REQ-014 Miss latency: cpu_resp one cycle after the edge that samples the final ddr_resp.
REQ-015 cpu_addr changes during FILL SHALL have no effect; the latched address is served.
REQ-016 flush in IDLE or RESP: all valid bits cleared at that edge; a simultaneous IDLE lookup SHALL be treated as miss.
REQ-017 flush during FILL: SHALL be recorded in a pending bit and applied when leaving FILL (after the filled line is validated, so the line is invalidated too); requested word still returned.
REQ-018 Only valid, tag, data arrays and the control registers SHALL be stored; no write path exists (ddr_write=0 always).
REQ-019 Data/tag arrays SHALL not require reset; valid bits SHALL.

Reset
REQ-020 rst_n=0 SHALL immediately force: state IDLE, all valid=0, k=0, flush-pending=0, cpu_resp=0, ddr_read=0, ddr_addr=0, cpu_rdata=0.
REQ-021 Reset during FILL SHALL abandon the refill; partially written line stays invalid; a late ddr_resp after release in IDLE SHALL be ignored.
REQ-022 First posedge with rst_n=1 SHALL be allowed to accept a request.

Verification (DDR model returns rdata = address ^ 32'hA5A5_0000, 3-cycle response latency)
REQ-023 Cold read 0x0000_0014 -> four ddr reads 0x10,0x14,0x18,0x1C in order; cpu_resp once with 0xA5A5_0014.
REQ-024 Then read 0x0000_0018 -> cpu_resp next cycle, 0xA5A5_0018, no ddr_read activity.
REQ-025 Read 0x0000_0094 (same index 1, different tag) -> refill 0x90..0x9C; re-read 0x14 -> miss again (evicted).
REQ-026 flush pulse in 2nd refill word of 0x20 line -> 0xA5A5_0020-line word returned; re-read 0x20 -> misses.
REQ-027 rst_n low during 3rd refill word -> ddr_read=0, cpu_resp=0 same time; after release read same address -> full 4-word refill.
REQ-028 Back-to-back hits 0x10,0x14,0x18 -> each cpu_resp exactly one cycle after its IDLE accept; cpu_resp never high two consecutive cycles.
